// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef struct packed {
        logic        op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } dmem_req_t;

    // Size/lane combinations that cannot be served by one word access.
    function automatic logic bad_align(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        return (size == SZ_RSVD)
            || (size == SZ_HALF && lane[0])
            || (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store-side merge and load-side extract/extend.
module dmem_lane_align (
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);
    import dmem_pkg::*;

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        wword_o = word_i;
        case (size_i)
            SZ_BYTE: wword_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            SZ_HALF: wword_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_WORD: wword_o = wdata_i;
            default: wword_o = word_i;
        endcase
    end

    always_comb begin
        bsel    = 8'(word_i >> {lane_i, 3'b000});
        hsel    = 16'(word_i >> {lane_i[1], 4'b0000});
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & bsel[7]}}, bsel};
            SZ_HALF: rdata_o = {{16{~unsigned_i & hsel[15]}}, hsel};
            SZ_WORD: rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: DEPTH words, byte/half/word access,
// fixed LATENCY stall handshake, error flag for bad accesses.
module data_memory_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o
);
    import dmem_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    dmem_req_t         req_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem_q [DEPTH];

    logic              req;
    dmem_req_t         in_req;
    dmem_req_t         cur;
    logic [ADDR_W-1:0] cur_addr;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              oor;
    logic              bad;
    logic [31:0]       word;
    logic [31:0]       st_word;
    logic [31:0]       ld_data;
    logic              latch;
    logic              commit;
    logic              fault;

    assign req = memRead_i | memWrite_i;

    always_comb begin
        in_req.op    = memWrite_i ? OP_STORE : OP_LOAD;
        in_req.size  = size_i;
        in_req.uns   = unsigned_i;
        in_req.wdata = wdata_i;
    end

    // In IDLE the access is decoded straight from the ports so that a
    // LATENCY==1 access can complete on the same edge it is sampled.
    assign cur      = (state_q == ST_IDLE) ? in_req : req_q;
    assign cur_addr = (state_q == ST_IDLE) ? addr_i : addr_q;
    assign lane     = cur_addr[1:0];
    assign idx      = cur_addr[IDX_W+1:2];
    assign oor      = (cur_addr >> (IDX_W + 2)) != '0;
    assign bad      = oor | bad_align(cur.size, lane);
    assign word     = mem_q[idx];

    dmem_lane_align u_align (
        .word_i     (word),
        .wdata_i    (cur.wdata),
        .size_i     (cur.size),
        .lane_i     (lane),
        .unsigned_i (cur.uns),
        .wword_o    (st_word),
        .rdata_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        fault   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (bad) begin
                        state_d = ST_DONE;
                        fault   = 1'b1;
                    end else if (LATENCY == 1) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q <= addr_i;
                req_q  <= in_req;
            end
            if (fault) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (commit) begin
                err_q <= 1'b0;
                if (cur.op == OP_LOAD) begin
                    rdata_q <= ld_data;
                end
            end
        end
    end

    // Array has no reset; a reset edge must still block the commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && cur.op == OP_STORE) begin
            mem_q[idx] <= st_word;
        end
    end

    assign stall_o = (state_q == ST_IDLE) ? req : (state_q == ST_BUSY);
    assign done_o  = (state_q == ST_DONE);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic        stall, done, err;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .ADDR_W  (32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .memRead_i  (memRead),
        .memWrite_i (memWrite),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .size_i     (size),
        .unsigned_i (uns),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .done_o     (done),
        .err_o      (err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_cnt = 0;
    logic [7:0]  mem_b [DEPTH*4];
    logic [31:0] last_rd = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endfunction

    // Reference: memory as a flat byte array, loads assembled arithmetically.
    task automatic model_push(input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz,
                              input logic u);
        exp_t   x;
        int     n;
        longint v;
        logic   is_bad;
        is_bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
              || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= DEPTH);
        if (is_bad) begin
            x.rdata = '0;
            x.err   = 1'b1;
            x.stall = 1;
            last_rd = '0;
        end else begin
            n       = 1 << sz;
            x.err   = 1'b0;
            x.stall = LAT;
            if (wr) begin
                for (int i = 0; i < n; i++) mem_b[a + i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v + (longint'(mem_b[a + i]) << (8 * i));
                if (!u && v[8*n-1]) v = v - (longint'(1) << (8 * n));
                last_rd = v[31:0];
            end
            x.rdata = last_rd;
        end
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done with empty queue, want none at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("err", 32'(err), 32'(e.err));
                chk("stall_cycles", stall_cnt, e.stall);
                chk("stall_in_done", 32'(stall), 32'd0);
            end
            stall_cnt = 0;
        end else if (stall) begin
            stall_cnt++;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic u);
        logic got;
        @(posedge clk);
        #1;
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = d;
        size     = sz;
        uns      = u;
        model_push(wr, a, d, sz, u);
        got = 1'b0;
        for (int c = 0; c < LAT + 5 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, want done within %0d cycles", LAT + 5);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        int          op;
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        addr = '0; wdata = '0; size = '0; uns = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);

        for (int w = 0; w < DEPTH; w++) access(1'b0, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0);

        access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0);
        access(1'b0, 1'b1, 32'h21, 32'h000000AA, 2'd0, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        access(1'b1, 1'b0, 32'h21, 32'h0, 2'd0, 1'b0);
        access(1'b1, 1'b0, 32'h21, 32'h0, 2'd0, 1'b1);
        access(1'b1, 1'b0, 32'h22, 32'h0, 2'd1, 1'b0);
        access(1'b1, 1'b0, 32'h22, 32'h0, 2'd2, 1'b0);
        access(1'b0, 1'b1, 32'h23, 32'h0000BBCC, 2'd1, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        access(1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, 2'd2, 1'b0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'd3, 1'b0);
        access(1'b1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0);

        @(posedge clk);
        #1;
        memRead = 1'b0; memWrite = 1'b1; addr = 32'h30;
        wdata = 32'h55; size = 2'd2; uns = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; memWrite = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        last_rd = '0;
        access(1'b1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0);

        access(1'b1, 1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0);
        access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);

        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, DEPTH * 4 + 7));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
            d  = $urandom;
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, d, sz, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
